if_fetch_unit: RTL

//  Instruction-fetch stage; drives if_pc_out/if_instr/if_stall/flush into the IF/ID pipeline register.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_buf.sv | 53 +++++
 rtl/if_fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, nop encoding and fetch FSM state encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int INSTR_WIDTH     = 32;
    localparam int INSTR_MEM_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [INSTR_MEM_WIDTH-1:0] word_align(input logic [INSTR_MEM_WIDTH-1:0] addr);
        return {addr[INSTR_MEM_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_buf.sv
// Single-entry holding register for one fetched pc/instruction pair; presents a nop when empty.
module if_fetch_buf
    import if_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       clear,
    input  logic                       consume,
    input  logic [INSTR_MEM_WIDTH-1:0] pc_in,
    input  logic [INSTR_WIDTH-1:0]     instr_in,
    output logic                       valid,
    output logic [INSTR_MEM_WIDTH-1:0] pc_out,
    output logic [INSTR_WIDTH-1:0]     instr_out
);

    logic                       valid_q, valid_d;
    logic [INSTR_MEM_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]     instr_q, instr_d;

    // A redirect clear outranks everything; load and consume never coincide.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid     = valid_q;
    assign pc_out    = pc_q;
    assign instr_out = valid_q ? instr_q : NOP_INSTR;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, single-outstanding imem handshake,
// one-entry instruction buffer toward IF/ID, and EX redirects that discard stale responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_MEM_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INSTR_MEM_WIDTH-1:0] PC_STEP  = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_id_en,
    input  logic                       redirect_valid,
    input  logic [INSTR_MEM_WIDTH-1:0] redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [INSTR_MEM_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0]     imem_resp_data,
    output logic [INSTR_MEM_WIDTH-1:0] if_pc_out,
    output logic [INSTR_WIDTH-1:0]     if_instr,
    output logic                       if_stall,
    output logic                       flush,
    output fetch_state_e               dbg_state
);

    // Handshake: a request transfers on a cycle where imem_req_valid & imem_req_ready are both 1;
    // once raised, valid and addr stay stable until that transfer. The response is a one-cycle
    // imem_resp_valid pulse with no ready, at least one cycle after the accepting edge.

    fetch_state_e               state_q, state_d;
    logic [INSTR_MEM_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_MEM_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                       buf_valid;
    logic                       buf_load;
    logic                       consume;
    logic                       req_fire;

    assign consume        = if_id_en & buf_valid;
    assign imem_req_valid = ~rst & (state_q == ST_IDLE) & ~redirect_valid & (~buf_valid | consume);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        buf_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    buf_load = ~redirect_valid;
                    state_d  = ST_IDLE;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The redirect target always wins over the sequential increment.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    if_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (redirect_valid),
        .consume   (consume),
        .pc_in     (req_pc_q),
        .instr_in  (imem_resp_data),
        .valid     (buf_valid),
        .pc_out    (if_pc_out),
        .instr_out (if_instr)
    );

    assign if_stall  = ~buf_valid;
    assign flush     = redirect_valid;
    assign dbg_state = state_q;

endmodule
